// File: rtl/sobel_pkg.sv
// Shared constants, control-flag bundle and helpers for the Sobel edge detector.
// Defaults target the 640x360 luma stream produced by the downsampling stage.
package sobel_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_LINE_WIDTH  = 640;
    localparam int DEFAULT_FRAME_LINES = 360;
    localparam int DEFAULT_EDGE_THRESH = 64;
    localparam int DEFAULT_COL_W       = $clog2(DEFAULT_LINE_WIDTH);

    // Signed gradient width: +/-1020 for 8-bit pixels.
    localparam int GRAD_W   = 11;
    localparam int PIPE_LAT = 4;

    // Per-pixel control flags that travel alongside the data pipeline.
    typedef struct packed {
        logic vsync;
        logic href;
        logic valid;
        logic mask;
    } ctl_t;

    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] v);
        logic [GRAD_W-1:0] u;
        u = v;
        return v[GRAD_W-1] ? (~u + GRAD_W'(1)) : u;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Single-port, read-first line memory with a registered read port.
// Holding rdata when en is low keeps the last fetched sample stable across href gaps.
module line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEFAULT_LINE_WIDTH,
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/sobel_edge_det.sv
// Streaming 3x3 Sobel edge detector: two cascaded line buffers, a sliding window,
// gradient magnitude with saturation and a thresholded edge flag, 4-cycle latency.
module sobel_edge_det
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int LINE_WIDTH  = DEFAULT_LINE_WIDTH,
    parameter int FRAME_LINES = DEFAULT_FRAME_LINES,
    parameter int EDGE_THRESH = DEFAULT_EDGE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vsync,
    input  logic                  in_href,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    output logic                  out_vsync,
    output logic                  out_href,
    output logic [DATA_WIDTH-1:0] out_pixel,
    output logic                  out_edge
);

    localparam int COL_W = $clog2(LINE_WIDTH);
    localparam int ROW_W = (FRAME_LINES > 3) ? $clog2(FRAME_LINES) : 2;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(FRAME_LINES - 1);
    localparam logic [GRAD_W-1:0] SAT_MAX  = GRAD_W'((1 << DATA_WIDTH) - 1);
    localparam logic [GRAD_W-1:0] THRESH   = GRAD_W'(EDGE_THRESH);

    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             frame_ok_reg;
    logic             pix_valid;
    logic             pix_mask;

    // A pixel coinciding with vsync is not counted and is never unmasked.
    assign pix_valid = in_href & ~in_vsync;
    // frame_ok keeps everything masked after a reset until a vsync realigns the counters.
    assign pix_mask  = in_vsync | ~frame_ok_reg
                     | (row_reg < ROW_W'(2)) | (col_reg < COL_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg      <= '0;
            row_reg      <= '0;
            frame_ok_reg <= 1'b0;
        end else if (in_vsync) begin
            col_reg      <= '0;
            row_reg      <= '0;
            frame_ok_reg <= 1'b1;
        end else if (in_href) begin
            if (col_reg == COL_LAST) begin
                col_reg <= '0;
                if (row_reg != ROW_LAST) begin
                    row_reg <= row_reg + 1'b1;
                end
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Control delay line; stage k holds flags of the pixel presented k+1 cycles earlier.
    ctl_t ctl_in;
    ctl_t ctl_reg [PIPE_LAT-1];

    always_comb begin
        ctl_in       = '0;
        ctl_in.vsync = in_vsync;
        ctl_in.href  = in_href;
        ctl_in.valid = pix_valid;
        ctl_in.mask  = pix_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT - 1; i++) begin
                ctl_reg[i] <= '0;
            end
        end else begin
            ctl_reg[0] <= ctl_in;
            for (int i = 1; i < PIPE_LAT - 1; i++) begin
                ctl_reg[i] <= ctl_reg[i-1];
            end
        end
    end

    logic [DATA_WIDTH-1:0] d1_pixel_reg;
    logic [COL_W-1:0]      d1_col_reg;
    logic [DATA_WIDTH-1:0] d2_pixel_reg;
    logic [DATA_WIDTH-1:0] d2_up_reg;
    logic [DATA_WIDTH-1:0] lb0_q;
    logic [DATA_WIDTH-1:0] lb1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_pixel_reg <= '0;
            d1_col_reg   <= '0;
            d2_pixel_reg <= '0;
            d2_up_reg    <= '0;
        end else begin
            d1_pixel_reg <= in_pixel;
            d1_col_reg   <= col_reg;
            d2_pixel_reg <= d1_pixel_reg;
            d2_up_reg    <= lb0_q;
        end
    end

    line_buf #(
        .DEPTH (LINE_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_lb0 (
        .clk   (clk),
        .en    (pix_valid),
        .we    (pix_valid),
        .addr  (col_reg),
        .wdata (in_pixel),
        .rdata (lb0_q)
    );

    // lb1 trails lb0 by one cycle so the row evicted from lb0 can be written at the
    // same address in the same access that reads out row r-2.
    line_buf #(
        .DEPTH (LINE_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_lb1 (
        .clk   (clk),
        .en    (ctl_reg[0].valid),
        .we    (ctl_reg[0].valid),
        .addr  (d1_col_reg),
        .wdata (lb0_q),
        .rdata (lb1_q)
    );

    // Newest window column, oldest row first.
    logic [DATA_WIDTH-1:0] new_col [3];
    logic [DATA_WIDTH-1:0] pn [3][3];

    assign new_col[0] = lb1_q;
    assign new_col[1] = d2_up_reg;
    assign new_col[2] = d2_pixel_reg;

    // Only the two most recent columns are stored; pn is the shifted window that the
    // gradient stage registers in the same edge the taps advance.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_row
            logic [DATA_WIDTH-1:0] tap_reg [2];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tap_reg[0] <= '0;
                    tap_reg[1] <= '0;
                end else if (ctl_reg[1].valid) begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= new_col[gi];
                end
            end

            assign pn[gi][0] = tap_reg[0];
            assign pn[gi][1] = tap_reg[1];
            assign pn[gi][2] = new_col[gi];
        end
    endgenerate

    logic [GRAD_W-1:0]        gx_pos;
    logic [GRAD_W-1:0]        gx_neg;
    logic [GRAD_W-1:0]        gy_pos;
    logic [GRAD_W-1:0]        gy_neg;
    logic signed [GRAD_W-1:0] gx_reg;
    logic signed [GRAD_W-1:0] gy_reg;

    always_comb begin
        gx_pos = GRAD_W'(pn[0][2]) + (GRAD_W'(pn[1][2]) << 1) + GRAD_W'(pn[2][2]);
        gx_neg = GRAD_W'(pn[0][0]) + (GRAD_W'(pn[1][0]) << 1) + GRAD_W'(pn[2][0]);
        gy_pos = GRAD_W'(pn[2][0]) + (GRAD_W'(pn[2][1]) << 1) + GRAD_W'(pn[2][2]);
        gy_neg = GRAD_W'(pn[0][0]) + (GRAD_W'(pn[0][1]) << 1) + GRAD_W'(pn[0][2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_reg <= '0;
            gy_reg <= '0;
        end else begin
            gx_reg <= $signed(gx_pos - gx_neg);
            gy_reg <= $signed(gy_pos - gy_neg);
        end
    end

    logic [GRAD_W-1:0] mag;
    assign mag = abs_grad(gx_reg) + abs_grad(gy_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync <= 1'b0;
            out_href  <= 1'b0;
            out_pixel <= '0;
            out_edge  <= 1'b0;
        end else begin
            out_vsync <= ctl_reg[2].vsync;
            out_href  <= ctl_reg[2].href;
            if (ctl_reg[2].valid && !ctl_reg[2].mask) begin
                out_pixel <= (mag > SAT_MAX) ? '1 : mag[DATA_WIDTH-1:0];
                out_edge  <= (mag >= THRESH);
            end else begin
                out_pixel <= '0;
                out_edge  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_det.sv
// Scoreboard bench for sobel_edge_det on a reduced 264x6 frame: directed patterns with
// hand-derived results, random frames against a direct Sobel model, and a mid-frame reset.
module tb_sobel_edge_det;

    localparam int DW   = 8;
    localparam int LW   = 264;
    localparam int FL   = 6;
    localparam int TH   = 64;
    localparam int HALF = LW / 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          in_vsync = 1'b0;
    logic          in_href  = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          out_vsync;
    logic          out_href;
    logic [DW-1:0] out_pixel;
    logic          out_edge;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [8:0]    exp_q [$];
    logic [DW-1:0] img [FL][LW];
    logic [3:0]    hist_h;
    logic [3:0]    hist_v;
    bit            frame_valid = 1'b0;

    sobel_edge_det #(
        .DATA_WIDTH  (DW),
        .LINE_WIDTH  (LW),
        .FRAME_LINES (FL),
        .EDGE_THRESH (TH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vsync  (in_vsync),
        .in_href   (in_href),
        .in_pixel  (in_pixel),
        .out_vsync (out_vsync),
        .out_href  (out_href),
        .out_pixel (out_pixel),
        .out_edge  (out_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [DW-1:0] gen_pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 8'h80;
            1:       return (c >= HALF) ? 8'hFF : 8'h00;
            2:       return 8'(c % 256);
            4:       return (c >= HALF) ? ((r < 3) ? 8'd16 : 8'd15) : 8'd0;
            default: return 8'($urandom);
        endcase
    endfunction

    // Expected {edge, pixel}; img[r][c] must already hold the current pixel.
    function automatic logic [8:0] expect_px(input int pat, input int r, input int c);
        int gx, gy, mag;
        if (!frame_valid || r < 2 || c < 2) return 9'd0;
        case (pat)
            0: return 9'd0;
            1: return (c == HALF || c == HALF + 1) ? {1'b1, 8'hFF} : 9'd0;
            2: return ((c % 256) < 2) ? {1'b1, 8'hFF} : {1'b0, 8'h08};
            default: begin
                gx = (int'(img[r-2][c]) + 2 * int'(img[r-1][c]) + int'(img[r][c]))
                   - (int'(img[r-2][c-2]) + 2 * int'(img[r-1][c-2]) + int'(img[r][c-2]));
                gy = (int'(img[r][c-2]) + 2 * int'(img[r][c-1]) + int'(img[r][c]))
                   - (int'(img[r-2][c-2]) + 2 * int'(img[r-2][c-1]) + int'(img[r-2][c]));
                mag = iabs(gx) + iabs(gy);
                return {(mag >= TH) ? 1'b1 : 1'b0, (mag > 255) ? 8'hFF : 8'(mag)};
            end
        endcase
    endfunction

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic drive(input logic v, input logic h, input logic [DW-1:0] p,
                         input logic [8:0] e, input bit push);
        in_vsync = v;
        in_href  = h;
        in_pixel = p;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int pat, input int gap, input int ar, input int ac);
        logic [DW-1:0] pix;
        drive(1'b1, 1'b0, '0, 9'd0, 1'b0);
        frame_valid = 1'b1;
        for (int r = 0; r < FL; r++) begin
            for (int c = 0; c < LW; c++) begin
                pix = gen_pix(pat, r, c);
                img[r][c] = pix;
                if (r == ar && c == ac) begin
                    in_vsync = 1'b0;
                    in_href  = 1'b1;
                    in_pixel = pix;
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("async_reset_outputs",
                          int'({out_vsync, out_href, out_edge, out_pixel}), 0);
                    in_href     = 1'b0;
                    in_pixel    = '0;
                    frame_valid = 1'b0;
                    exp_q.delete();
                    repeat (2) @(posedge clk);
                    #3;
                    rst_n = 1'b1;
                    @(posedge clk);
                    #1;
                    return;
                end
                drive(1'b0, 1'b1, pix, expect_px(pat, r, c), 1'b1);
                if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))
                    drive(1'b0, 1'b0, '0, 9'd0, 1'b0);
            end
            if (gap != 0) repeat (2) drive(1'b0, 1'b0, '0, 9'd0, 1'b0);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_h <= '0;
            hist_v <= '0;
        end else begin
            hist_h <= {hist_h[2:0], in_href};
            hist_v <= {hist_v[2:0], in_vsync};
        end
    end

    // Monitor: latency of the framing signals every cycle, scoreboard pop on out_href.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            check("latency_href", int'(out_href), int'(hist_h[3]));
            check("latency_vsync", int'(out_vsync), int'(hist_v[3]));
            if (out_href) begin
                check("scoreboard_pop", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_pixel", int'(out_pixel), int'(e[7:0]));
                    check("out_edge", int'(out_edge), int'(e[8]));
                end
            end else begin
                check("idle_zero", int'({out_edge, out_pixel}), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'({out_vsync, out_href, out_edge, out_pixel}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(0, 1, -1, -1);   // flat 0x80, gap after every pixel
        send_frame(1, 0, -1, -1);   // vertical step, back-to-back frame
        send_frame(2, 2, -1, -1);   // horizontal ramp with random gaps
        send_frame(3, 2, -1, -1);   // random data against the model
        send_frame(4, 0, -1, -1);   // magnitudes straddling the threshold
        send_frame(3, 0, 3, 100);   // reset asserted mid-frame

        // Without a vsync after reset every output stays masked.
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < LW; c++)
                drive(1'b0, 1'b1, 8'($urandom), 9'd0, 1'b1);

        send_frame(3, 1, -1, -1);
        repeat (8) drive(1'b0, 1'b0, '0, 9'd0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
